// File: rtl/seg_disp_pkg.sv
// Shared constants and helpers for the seven-segment display datapath.
// Segment patterns are active-high, bit 0 = a ... bit 6 = g; polarity is
// applied only at the output register of the driver.
package seg_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-low one-hot digit select codes
  localparam logic [3:0] SEL_D0 = 4'b1110;
  localparam logic [3:0] SEL_D1 = 4'b1101;
  localparam logic [3:0] SEL_D2 = 4'b1011;
  localparam logic [3:0] SEL_D3 = 4'b0111;

  // True when exactly one bit of the select vector is low
  function automatic logic sel_is_valid(input logic [3:0] s);
    logic [3:0] on;
    on = ~s;
    return (on != 4'd0) && ((on & (on - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-high seven-segment pattern converter.
// With HEX_EN=0 the non-decimal nibbles render as a dash.
module seg7_decode
  import seg_disp_pkg::*;
#(
  parameter bit HEX_EN = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] pat
);

  // Lookup of the glyph for the selected nibble
  always_comb begin
    pat = SEG_DASH;
    case (nibble)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = HEX_EN ? SEG_A : SEG_DASH;
      4'hB: pat = HEX_EN ? SEG_B : SEG_DASH;
      4'hC: pat = HEX_EN ? SEG_C : SEG_DASH;
      4'hD: pat = HEX_EN ? SEG_D : SEG_DASH;
      4'hE: pat = HEX_EN ? SEG_E : SEG_DASH;
      4'hF: pat = HEX_EN ? SEG_F : SEG_DASH;
      default: pat = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_data_drv.sv
// Segment-data driver for a 4-digit multiplexed seven-segment display.
// seg is registered against the predicted next select so that segment data
// and digit select switch on the same edge. New values wait in a pending
// register and are only committed at the start of a frame (digit 3).
module seg_data_drv
  import seg_disp_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN         = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sel,
  input  logic        disp_en,
  input  logic        data_valid,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic        data_ready,
  output logic [7:0]  seg,
  output logic        frame_sync
);

  logic [15:0] disp_q;
  logic [3:0]  dp_q;
  logic [15:0] pend_q;
  logic [3:0]  pend_dp_q;
  logic        pending_q;
  logic [7:0]  seg_p1;
  logic        fs_p1;

  logic [3:0]  nsel;
  logic        sel_ok;
  logic        commit;
  logic [15:0] eff_data;
  logic [3:0]  eff_dp;
  logic        z3, z2, z1;
  logic [3:0]  nib;
  logic        dp_bit;
  logic        blank;
  logic [6:0]  pat;
  logic [7:0]  seg_hi;

  // Map an active-high pattern onto the pin polarity
  function automatic logic [7:0] apply_pol(input logic [7:0] x);
    return SEG_ACTIVE_LOW ? ~x : x;
  endfunction

  assign nsel     = {sel[2:0], sel[3]};
  assign sel_ok   = sel_is_valid(sel);
  assign commit   = sel_ok && (sel == SEL_D2) && pending_q;
  // At the commit edge digit 3 must already show the new value
  assign eff_data = commit ? pend_q : disp_q;
  assign eff_dp   = commit ? pend_dp_q : dp_q;
  assign z3       = (eff_data[15:12] == 4'h0);
  assign z2       = (eff_data[11:8] == 4'h0);
  assign z1       = (eff_data[7:4] == 4'h0);

  // Select nibble, decimal point and blanking for the digit shown next
  always_comb begin
    nib    = eff_data[3:0];
    dp_bit = eff_dp[0];
    blank  = 1'b0;
    case (nsel)
      SEL_D0: begin
        nib    = eff_data[3:0];
        dp_bit = eff_dp[0];
      end
      SEL_D1: begin
        nib    = eff_data[7:4];
        dp_bit = eff_dp[1];
        blank  = BLANK_LZ && z3 && z2 && z1;
      end
      SEL_D2: begin
        nib    = eff_data[11:8];
        dp_bit = eff_dp[2];
        blank  = BLANK_LZ && z3 && z2;
      end
      SEL_D3: begin
        nib    = eff_data[15:12];
        dp_bit = eff_dp[3];
        blank  = BLANK_LZ && z3;
      end
      default: ;
    endcase
  end

  seg7_decode #(.HEX_EN(HEX_EN)) u_dec (
    .nibble (nib),
    .pat    (pat)
  );

  // Final active-high segment word; an illegal select or a disabled display forces all off
  always_comb begin
    seg_hi = {dp_bit, blank ? SEG_BLANK : pat};
    if (!disp_en || !sel_ok) seg_hi = 8'h00;
  end

  // ---- stage p1: registered segments, handshake and frame commit ----
  // Output register plus pending/display bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p1    <= apply_pol(8'h00);
      fs_p1     <= 1'b0;
      pending_q <= 1'b0;
      pend_q    <= 16'h0000;
      pend_dp_q <= 4'h0;
      disp_q    <= 16'h0000;
      dp_q      <= 4'h0;
    end else begin
      seg_p1 <= apply_pol(seg_hi);
      fs_p1  <= commit;
      if (commit) begin
        disp_q    <= pend_q;
        dp_q      <= pend_dp_q;
        pending_q <= 1'b0;
      end else if (data_valid && !pending_q) begin
        pend_q    <= data_in;
        pend_dp_q <= dp_in;
        pending_q <= 1'b1;
      end
    end
  end

  assign seg        = seg_p1;
  assign frame_sync = fs_p1;
  assign data_ready = !pending_q;

endmodule

// File: tb/tb_seg_data_drv.sv
// Directed bench for seg_data_drv: four instances with different parameter
// sets share the same stimulus; the bench emulates the digit-select rotator.
module tb_seg_data_drv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sel = 4'b0111;
  logic        disp_en = 1'b1;
  logic        data_valid = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  bit          rot_en = 1'b1;

  logic [7:0] seg_a, seg_nlz, seg_nhx, seg_ah;
  logic       rdy_a, rdy_nlz, rdy_nhx, rdy_ah;
  logic       fs_a, fs_nlz, fs_nhx, fs_ah;

  logic [7:0] fa [4];
  logic [7:0] fnlz [4];
  logic [7:0] fnhx [4];
  logic [7:0] fah [4];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg_data_drv u_dut (
    .clk(clk), .rst(rst), .sel(sel), .disp_en(disp_en), .data_valid(data_valid),
    .data_in(data_in), .dp_in(dp_in), .data_ready(rdy_a), .seg(seg_a), .frame_sync(fs_a)
  );
  seg_data_drv #(.BLANK_LZ(1'b0)) u_nlz (
    .clk(clk), .rst(rst), .sel(sel), .disp_en(disp_en), .data_valid(data_valid),
    .data_in(data_in), .dp_in(dp_in), .data_ready(rdy_nlz), .seg(seg_nlz), .frame_sync(fs_nlz)
  );
  seg_data_drv #(.HEX_EN(1'b0)) u_nhx (
    .clk(clk), .rst(rst), .sel(sel), .disp_en(disp_en), .data_valid(data_valid),
    .data_in(data_in), .dp_in(dp_in), .data_ready(rdy_nhx), .seg(seg_nhx), .frame_sync(fs_nhx)
  );
  seg_data_drv #(.SEG_ACTIVE_LOW(1'b0)) u_ah (
    .clk(clk), .rst(rst), .sel(sel), .disp_en(disp_en), .data_valid(data_valid),
    .data_in(data_in), .dp_in(dp_in), .data_ready(rdy_ah), .seg(seg_ah), .frame_sync(fs_ah)
  );

  // One clock; afterwards sel advances as the rotator would
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rot_en) sel = {sel[2:0], sel[3]};
  endtask

  task automatic align(input logic [3:0] tgt, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (sel == tgt) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  function automatic int dig_of(input logic [3:0] s);
    case (s)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic grab();
    int d;
    d = dig_of(sel);
    fa[d]   = seg_a;
    fnlz[d] = seg_nlz;
    fnhx[d] = seg_nhx;
    fah[d]  = seg_ah;
  endtask

  // Transfer at a digit-0 slot, wait for the commit, capture the next frame
  task automatic load_and_commit(input logic [15:0] v, input logic [3:0] dp, output bit ok);
    bit al;
    ok = 1'b0;
    align(4'b1110, al);
    data_valid = 1'b1;
    data_in = v;
    dp_in = dp;
    cyc();
    data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (fs_a === 1'b1) begin
        ok = al;
        break;
      end
      cyc();
    end
    grab();
    for (int i = 0; i < 3; i++) begin
      cyc();
      grab();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    total++;
    if (seg_a !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=ff", seg_a); end
    total++;
    if (seg_ah !== 8'h00) begin bad++; $display("FAIL reset_seg_ah got=%h want=00", seg_ah); end
    total++;
    if (rdy_a !== 1'b1 || fs_a !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl ready=%b fs=%b want ready=1 fs=0", rdy_a, fs_a);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (seg_a !== ((sel == 4'b1110) ? 8'hC0 : 8'hFF)) begin
        bad++; $display("FAIL reset_disp sel=%b got=%h want=%h", sel, seg_a, (sel == 4'b1110) ? 8'hC0 : 8'hFF);
      end
      total++;
      if (seg_ah !== ((sel == 4'b1110) ? 8'h3F : 8'h00)) begin
        bad++; $display("FAIL reset_disp_ah sel=%b got=%h", sel, seg_ah);
      end
      total++;
      if (rdy_a !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", rdy_a); end
    end
  endtask

  task automatic test_load();
    bit al;
    align(4'b1110, al);
    total++;
    if (!al) begin bad++; $display("FAIL load_align got=0 want=1"); end
    data_valid = 1'b1;
    data_in = 16'h1234;
    dp_in = 4'b0100;
    cyc();
    data_valid = 1'b0;
    total++;
    if (rdy_a !== 1'b0 || fs_a !== 1'b0) begin
      bad++; $display("FAIL load_accept ready=%b fs=%b want ready=0 fs=0", rdy_a, fs_a);
    end
    cyc();
    total++;
    if (rdy_a !== 1'b0 || fs_a !== 1'b0) begin
      bad++; $display("FAIL load_hold ready=%b fs=%b want ready=0 fs=0", rdy_a, fs_a);
    end
    cyc();
    total++;
    if (fs_a !== 1'b1) begin bad++; $display("FAIL load_fs got=%b want=1", fs_a); end
    total++;
    if (rdy_a !== 1'b1) begin bad++; $display("FAIL load_ready_after got=%b want=1", rdy_a); end
    total++;
    if (seg_a !== 8'hF9 || seg_ah !== 8'h06) begin
      bad++; $display("FAIL load_d3 got=%h/%h want=f9/06", seg_a, seg_ah);
    end
    cyc();
    total++;
    if (seg_a !== 8'h99 || seg_ah !== 8'h66 || fs_a !== 1'b0) begin
      bad++; $display("FAIL load_d0 got=%h/%h fs=%b want=99/66 fs=0", seg_a, seg_ah, fs_a);
    end
    cyc();
    total++;
    if (seg_a !== 8'hB0 || seg_ah !== 8'h4F) begin
      bad++; $display("FAIL load_d1 got=%h/%h want=b0/4f", seg_a, seg_ah);
    end
    cyc();
    total++;
    if (seg_a !== 8'h24 || seg_ah !== 8'hDB) begin
      bad++; $display("FAIL load_d2 got=%h/%h want=24/db", seg_a, seg_ah);
    end
  endtask

  task automatic test_blanking();
    bit ok;
    load_and_commit(16'h0070, 4'h0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL blank_commit got=0 want=1"); end
    total++;
    if ({fa[3], fa[2], fa[1], fa[0]} !== 32'hFFFF_F8C0) begin
      bad++; $display("FAIL blank_lz got=%h%h%h%h want=fffff8c0", fa[3], fa[2], fa[1], fa[0]);
    end
    total++;
    if ({fnlz[3], fnlz[2], fnlz[1], fnlz[0]} !== 32'hC0C0_F8C0) begin
      bad++; $display("FAIL blank_off got=%h%h%h%h want=c0c0f8c0", fnlz[3], fnlz[2], fnlz[1], fnlz[0]);
    end
  endtask

  task automatic test_hex();
    bit ok;
    load_and_commit(16'hABCF, 4'h0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL hex_commit got=0 want=1"); end
    total++;
    if ({fa[3], fa[2], fa[1], fa[0]} !== 32'h8883_C68E) begin
      bad++; $display("FAIL hex_on got=%h%h%h%h want=8883c68e", fa[3], fa[2], fa[1], fa[0]);
    end
    total++;
    if ({fnhx[3], fnhx[2], fnhx[1], fnhx[0]} !== 32'hBFBF_BFBF) begin
      bad++; $display("FAIL hex_off got=%h%h%h%h want=bfbfbfbf", fnhx[3], fnhx[2], fnhx[1], fnhx[0]);
    end
  endtask

  task automatic test_back_to_back();
    bit al;
    align(4'b1110, al);
    data_valid = 1'b1;
    data_in = 16'h1111;
    dp_in = 4'h0;
    cyc();
    total++;
    if (!al || rdy_a !== 1'b0) begin bad++; $display("FAIL b2b_first_accept ready=%b want=0", rdy_a); end
    data_in = 16'h2222;
    cyc();
    total++;
    if (rdy_a !== 1'b0 || fs_a !== 1'b0) begin
      bad++; $display("FAIL b2b_wait ready=%b fs=%b want ready=0 fs=0", rdy_a, fs_a);
    end
    cyc();
    total++;
    if (fs_a !== 1'b1 || seg_a !== 8'hF9 || rdy_a !== 1'b1) begin
      bad++; $display("FAIL b2b_commit1 fs=%b seg=%h ready=%b want fs=1 seg=f9 ready=1", fs_a, seg_a, rdy_a);
    end
    cyc();
    total++;
    if (rdy_a !== 1'b0 || seg_a !== 8'hF9) begin
      bad++; $display("FAIL b2b_second_accept ready=%b seg=%h want ready=0 seg=f9", rdy_a, seg_a);
    end
    data_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++;
      if (seg_a !== 8'hF9 || fs_a !== 1'b0) begin
        bad++; $display("FAIL b2b_frame1 seg=%h fs=%b want seg=f9 fs=0", seg_a, fs_a);
      end
    end
    cyc();
    total++;
    if (fs_a !== 1'b1 || seg_a !== 8'hA4) begin
      bad++; $display("FAIL b2b_commit2 fs=%b seg=%h want fs=1 seg=a4", fs_a, seg_a);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (seg_a !== 8'hA4) begin bad++; $display("FAIL b2b_frame2 seg=%h want=a4", seg_a); end
    end
  endtask

  task automatic test_bad_sel();
    rot_en = 1'b0;
    sel = 4'b0011;
    data_valid = 1'b1;
    data_in = 16'h5678;
    dp_in = 4'h0;
    cyc();
    data_valid = 1'b0;
    total++;
    if (seg_a !== 8'hFF || rdy_a !== 1'b0) begin
      bad++; $display("FAIL badsel_accept seg=%h ready=%b want seg=ff ready=0", seg_a, rdy_a);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (seg_a !== 8'hFF || fs_a !== 1'b0 || rdy_a !== 1'b0) begin
        bad++; $display("FAIL badsel_hold seg=%h fs=%b ready=%b want seg=ff fs=0 ready=0", seg_a, fs_a, rdy_a);
      end
    end
    sel = 4'b1011;
    rot_en = 1'b1;
    cyc();
    total++;
    if (fs_a !== 1'b1 || seg_a !== 8'h92) begin
      bad++; $display("FAIL badsel_resume fs=%b seg=%h want fs=1 seg=92", fs_a, seg_a);
    end
    cyc();
    total++;
    if (seg_a !== 8'h80) begin bad++; $display("FAIL badsel_d0 seg=%h want=80", seg_a); end
  endtask

  task automatic test_disp_en();
    bit al;
    bit seen;
    align(4'b1110, al);
    disp_en = 1'b0;
    data_valid = 1'b1;
    data_in = 16'h0042;
    dp_in = 4'h0;
    cyc();
    data_valid = 1'b0;
    total++;
    if (seg_a !== 8'hFF) begin bad++; $display("FAIL dispen_off seg=%h want=ff", seg_a); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (fs_a === 1'b1) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    total++;
    if (!seen || seg_a !== 8'hFF) begin
      bad++; $display("FAIL dispen_commit fs_seen=%b seg=%h want fs_seen=1 seg=ff", seen, seg_a);
    end
    disp_en = 1'b1;
    cyc();
    total++;
    if (seg_a !== 8'hA4) begin bad++; $display("FAIL dispen_d0 seg=%h want=a4", seg_a); end
    cyc();
    total++;
    if (seg_a !== 8'h99) begin bad++; $display("FAIL dispen_d1 seg=%h want=99", seg_a); end
    cyc();
    total++;
    if (seg_a !== 8'hFF) begin bad++; $display("FAIL dispen_d2 seg=%h want=ff", seg_a); end
  endtask

  task automatic test_reset_pending();
    bit al;
    align(4'b1110, al);
    data_valid = 1'b1;
    data_in = 16'h8888;
    dp_in = 4'hF;
    cyc();
    data_valid = 1'b0;
    total++;
    if (rdy_a !== 1'b0) begin bad++; $display("FAIL rstp_pending ready=%b want=0", rdy_a); end
    rst = 1'b1;
    cyc();
    total++;
    if (seg_a !== 8'hFF || rdy_a !== 1'b1 || fs_a !== 1'b0) begin
      bad++; $display("FAIL rstp_reset seg=%h ready=%b fs=%b want seg=ff ready=1 fs=0", seg_a, rdy_a, fs_a);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      total++;
      if (fs_a !== 1'b0 || seg_a !== ((sel == 4'b1110) ? 8'hC0 : 8'hFF)) begin
        bad++; $display("FAIL rstp_disp sel=%b seg=%h fs=%b want seg=%h fs=0", sel, seg_a, fs_a,
                        (sel == 4'b1110) ? 8'hC0 : 8'hFF);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_blanking();
    test_hex();
    test_back_to_back();
    test_bad_sel();
    test_disp_en();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
